pixel_bram_loader: RTL and testbench

- Upstream feeder for the cross-correlation core's image and template BRAM ports.
- Accepts a stream of 8-bit pixels and packs four pixels into each 32-bit word.
- Writes each word to the BRAM with a byte address and a 4-bit byte write enable, matching the core's `img_*` / `tmpl_*` port conventions.
- Two instances are used: one for the image (ADDR_WIDTH 20), one for the template (ADDR_WIDTH 18).

---
 rtl/pixel_bram_loader.sv | 175 +++++++++++++++++
 tb/tb_pixel_bram_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_bram_loader.sv
// Packs an 8-bit pixel stream into 32-bit BRAM words with byte enables and framing checks.
// Optional macro PIXEL_BRAM_LOADER_MSB_FIRST_EN: first pixel of each word goes to the top lane.
module pixel_bram_loader #(
    parameter int PIXEL_WIDTH = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 20,
    parameter int CNT_WIDTH   = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [ADDR_WIDTH-1:0]  base_addr_i,
    input  logic [CNT_WIDTH-1:0]   num_pixels_i,
    input  logic [PIXEL_WIDTH-1:0] s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic [ADDR_WIDTH-1:0]  bram_addr_o,
    output logic [DATA_WIDTH-1:0]  bram_data_o,
    output logic [3:0]             bram_we_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-3:0]   base_r;
    logic [ADDR_WIDTH-3:0]   word_idx_r;
    logic [CNT_WIDTH-1:0]    num_r;
    logic [CNT_WIDTH-1:0]    pix_cnt_r;
    logic [DATA_WIDTH-1:0]   pack_r;

    logic                    accept_s;
    logic [1:0]              lane_idx_s;
    logic [1:0]              phys_lane_s;
    logic                    count_end_s;
    logic                    final_s;
    logic                    word_done_s;
    logic                    frame_err_s;
    logic [DATA_WIDTH-1:0]   merged_s;
    logic [3:0]              mask_s;

    // Maps the pixel position within a word to its physical byte lane.
    function automatic logic [1:0] lane_map(input logic [1:0] idx);
`ifdef PIXEL_BRAM_LOADER_MSB_FIRST_EN
        return 2'd3 - idx;
`else
        return idx;
`endif
    endfunction

    // Byte enables for a word whose last filled position is idx.
    function automatic logic [3:0] we_mask(input logic [1:0] idx);
`ifdef PIXEL_BRAM_LOADER_MSB_FIRST_EN
        return 4'b1111 << (2'd3 - idx);
`else
        return 4'b1111 >> (2'd3 - idx);
`endif
    endfunction

    // Decodes the current transfer: lane placement, word completion and framing status.
    always_comb begin
        accept_s    = 1'b0;
        lane_idx_s  = pix_cnt_r[1:0];
        phys_lane_s = lane_map(lane_idx_s);
        count_end_s = 1'b0;
        final_s     = 1'b0;
        word_done_s = 1'b0;
        frame_err_s = 1'b0;
        mask_s      = we_mask(lane_idx_s);
        merged_s    = pack_r;
        merged_s[phys_lane_s*PIXEL_WIDTH +: PIXEL_WIDTH] = s_tdata;
        if (state_r == RUN) begin
            accept_s = s_tvalid & s_tready;
        end else begin
            accept_s = 1'b0;
        end
        // Words always start on a multiple of four pixels, so the low count bits give the lane.
        count_end_s = ((pix_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1}) == num_r);
        final_s     = count_end_s | s_tlast;
        word_done_s = (lane_idx_s == 2'd3) | final_s;
        frame_err_s = s_tlast ^ count_end_s;
    end

    // Load sequencer with registered stream handshake, BRAM write port and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            base_r      <= '0;
            word_idx_r  <= '0;
            num_r       <= '0;
            pix_cnt_r   <= '0;
            pack_r      <= '0;
            s_tready    <= 1'b0;
            bram_addr_o <= '0;
            bram_data_o <= '0;
            bram_we_o   <= 4'b0000;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_o    <= 1'b0;
                    bram_we_o <= 4'b0000;
                    s_tready  <= 1'b0;
                    if (start_i) begin
                        base_r     <= base_addr_i[ADDR_WIDTH-1:2];
                        num_r      <= num_pixels_i;
                        pix_cnt_r  <= '0;
                        word_idx_r <= '0;
                        pack_r     <= '0;
                        err_o      <= 1'b0;
                        busy_o     <= 1'b1;
                        if (num_pixels_i == '0) begin
                            state_r <= DONE;
                        end else begin
                            state_r  <= RUN;
                            s_tready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    bram_we_o <= 4'b0000;
                    if (accept_s) begin
                        pix_cnt_r <= pix_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        if (word_done_s) begin
                            bram_we_o   <= mask_s;
                            bram_data_o <= merged_s;
                            bram_addr_o <= {base_r + word_idx_r, 2'b00};
                            word_idx_r  <= word_idx_r + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
                            pack_r      <= '0;
                        end else begin
                            pack_r <= merged_s;
                        end
                        if (frame_err_s) begin
                            err_o <= 1'b1;
                        end
                        if (final_s) begin
                            state_r  <= FLUSH;
                            s_tready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    bram_we_o <= 4'b0000;
                    s_tready  <= 1'b0;
                    state_r   <= DONE;
                end
                DONE: begin
                    bram_we_o <= 4'b0000;
                    s_tready  <= 1'b0;
                    done_o    <= 1'b1;
                    busy_o    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    s_tready  <= 1'b0;
                    bram_we_o <= 4'b0000;
                    busy_o    <= 1'b0;
                    done_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_bram_loader.sv
// Directed table-driven bench for pixel_bram_loader (default little-endian lane order).
module tb_pixel_bram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [19:0] base_addr_i = 20'h0;
    logic [17:0] num_pixels_i = 18'h0;
    logic [7:0]  s_tdata = 8'h0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [19:0] bram_addr_o;
    logic [31:0] bram_data_o;
    logic [3:0]  bram_we_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_cmp = 0;
    int n_fail = 0;

    pixel_bram_loader dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .num_pixels_i(num_pixels_i), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready), .bram_addr_o(bram_addr_o),
        .bram_data_o(bram_data_o), .bram_we_o(bram_we_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [19:0] base;
        logic [17:0] num;
        int          n_send;
        int          tlast_pos;
        logic [7:0]  first;
        bit          toggle;
        bit          busy_start;
        int          exp_n;
        logic [19:0] a0;
        logic [31:0] d0;
        logic [3:0]  w0;
        logic [19:0] a1;
        logic [31:0] d1;
        logic [3:0]  w1;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_load(input vec_t v);
        int          pix, cyc, nw, done_cyc, last_acc;
        bit          drove, acc_now, done_seen, extra_ready;
        logic [19:0] wa[4];
        logic [31:0] wd[4];
        logic [3:0]  ww[4];
        bit          wl[4];
        for (int i = 0; i < 4; i++) begin
            wa[i] = 20'h0; wd[i] = 32'h0; ww[i] = 4'h0; wl[i] = 1'b0;
        end
        @(negedge clk);
        start_i = 1'b1; base_addr_i = v.base; num_pixels_i = v.num; s_tvalid = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        pix = 0; cyc = 0; nw = 0; done_cyc = 0; last_acc = -10;
        done_seen = 1'b0; extra_ready = 1'b0;
        while (!done_seen && cyc < 200) begin
            if (v.busy_start && cyc == 1) begin
                start_i = 1'b1; base_addr_i = 20'h0; num_pixels_i = 18'd1;
            end else begin
                start_i = 1'b0;
            end
            if (pix < v.n_send) begin
                s_tvalid = v.toggle ? (cyc % 2 == 0) : 1'b1;
                s_tdata  = 8'(v.first + pix);
                s_tlast  = (pix + 1 == v.tlast_pos);
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            drove = s_tvalid && s_tready;
            @(negedge clk);
            cyc++;
            acc_now = drove;
            if (drove) begin
                pix++;
                last_acc = cyc;
            end
            if (pix >= v.n_send && !acc_now && s_tready) extra_ready = 1'b1;
            if (bram_we_o != 4'b0000) begin
                if (nw < 4) begin
                    wa[nw] = bram_addr_o; wd[nw] = bram_data_o; ww[nw] = bram_we_o; wl[nw] = acc_now;
                end
                nw++;
            end
            if (done_o) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
        start_i = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        chk({v.name, " done_seen"}, 32'(done_seen), 32'd1);
        chk({v.name, " accepted"}, 32'(pix), 32'(v.n_send));
        chk({v.name, " nwrites"}, 32'(nw), 32'(v.exp_n));
        chk({v.name, " addr0"}, 32'(wa[0]), 32'(v.a0));
        chk({v.name, " data0"}, wd[0], v.d0);
        chk({v.name, " we0"}, 32'(ww[0]), 32'(v.w0));
        chk({v.name, " lat0"}, 32'(wl[0]), 32'd1);
        if (v.exp_n > 1) begin
            chk({v.name, " addr1"}, 32'(wa[1]), 32'(v.a1));
            chk({v.name, " data1"}, wd[1], v.d1);
            chk({v.name, " we1"}, 32'(ww[1]), 32'(v.w1));
            chk({v.name, " lat1"}, 32'(wl[1]), 32'd1);
        end
        chk({v.name, " done_lat"}, 32'(done_cyc - last_acc), 32'd2);
        chk({v.name, " err"}, 32'(err_o), 32'(v.exp_err));
        chk({v.name, " busy_at_done"}, 32'(busy_o), 32'd0);
        chk({v.name, " extra_ready"}, 32'(extra_ready), 32'd0);
        @(negedge clk);
        chk({v.name, " done_pulse"}, 32'(done_o), 32'd0);
        chk({v.name, " we_idle"}, 32'(bram_we_o), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " tready"}, 32'(s_tready), 32'd0);
        chk({tag, " we"}, 32'(bram_we_o), 32'd0);
        chk({tag, " addr"}, 32'(bram_addr_o), 32'd0);
        chk({tag, " data"}, bram_data_o, 32'd0);
        chk({tag, " busy"}, 32'(busy_o), 32'd0);
        chk({tag, " done"}, 32'(done_o), 32'd0);
        chk({tag, " err"}, 32'(err_o), 32'd0);
    endtask

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  done_at;
        bit  any_we, any_ready;
        vec_t v;

        vecs[0] = '{"basic",   20'h00100, 18'd8, 8, 8, 8'h01, 1'b0, 1'b0, 2,
                    20'h00100, 32'h04030201, 4'hF, 20'h00104, 32'h08070605, 4'hF, 1'b0};
        vecs[1] = '{"partial", 20'h00200, 18'd6, 6, 6, 8'hAA, 1'b0, 1'b1, 2,
                    20'h00200, 32'hADACABAA, 4'hF, 20'h00204, 32'h0000AFAE, 4'h3, 1'b0};
        vecs[2] = '{"early",   20'h00300, 18'd8, 5, 5, 8'h11, 1'b0, 1'b0, 2,
                    20'h00300, 32'h14131211, 4'hF, 20'h00304, 32'h00000015, 4'h1, 1'b1};
        vecs[3] = '{"wrap",    20'hFFFFC, 18'd8, 8, 8, 8'h01, 1'b1, 1'b0, 2,
                    20'hFFFFC, 32'h04030201, 4'hF, 20'h00000, 32'h08070605, 4'hF, 1'b0};
        vecs[4] = '{"notlast", 20'h00402, 18'd3, 3, 0, 8'h31, 1'b0, 1'b0, 1,
                    20'h00400, 32'h00333231, 4'h7, 20'h00000, 32'h00000000, 4'h0, 1'b1};

        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b1;

        for (int i = 0; i < 5; i++) run_load(vecs[i]);

        // Zero-length load: done without any stream or write activity, err cleared.
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 20'h00800; num_pixels_i = 18'd0;
        @(negedge clk);
        start_i = 1'b0;
        done_at = -1; any_we = 1'b0; any_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_o && done_at < 0) done_at = i;
            if (bram_we_o != 4'b0000) any_we = 1'b1;
            if (s_tready) any_ready = 1'b1;
        end
        chk("zero done_at", 32'(done_at), 32'd0);
        chk("zero we", 32'(any_we), 32'd0);
        chk("zero ready", 32'(any_ready), 32'd0);
        chk("zero err", 32'(err_o), 32'd0);

        // Reset in the middle of a word: everything returns to reset values, no write.
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 20'h00600; num_pixels_i = 18'd8;
        @(negedge clk);
        start_i = 1'b0;
        any_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1; s_tdata = 8'(8'h51 + i); s_tlast = 1'b0;
            @(negedge clk);
            if (bram_we_o != 4'b0000) any_we = 1'b1;
        end
        s_tvalid = 1'b0;
        chk("midrst busy_before", 32'(busy_o), 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        chk("midrst no_write", 32'(any_we), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        v = '{"after_rst", 20'h00700, 18'd4, 4, 4, 8'h41, 1'b0, 1'b0, 1,
              20'h00700, 32'h44434241, 4'hF, 20'h00000, 32'h00000000, 4'h0, 1'b0};
        run_load(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
